// File: rtl/uvmt_i2c_st_tagt_pkg.sv
// Shared types and constants for the I2C self-test target responder.
package uvmt_i2c_st_tagt_pkg;

   // Protocol states of the target FSM.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_PTR,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } tagt_state_e;

   // The bit counter has to reach 8 while a read byte is being shifted out.
   localparam int BIT_CNT_W = 4;

   // Bus levels of the acknowledge bit.
   localparam logic ACK_BIT  = 1'b0;
   localparam logic NACK_BIT = 1'b1;

   // SDA is open-drain, so putting a bit on the bus means pulling low for a 0.
   function automatic logic oe_for_bit(input logic bit_val);
      return ~bit_val;
   endfunction

endpackage

// File: rtl/uvmt_i2c_st_tagt_sync.sv
// Two-flop synchronizer for one asynchronous bus line, with registered
// rise/fall strobes that line up with the registered level output.
module uvmt_i2c_st_tagt_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic synced;

   // Both bus lines idle high, so the flops reset to 1 to avoid a false edge
   // straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta   <= 1'b1;
         synced <= 1'b1;
         level  <= 1'b1;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         meta   <= async_in;
         synced <= meta;
         level  <= synced;
         rise   <= synced & ~level;
         fall   <= ~synced & level;
      end
   end

endmodule

// File: rtl/uvmt_i2c_st_tagt_dut.sv
// I2C target responder: decodes START/STOP, matches a 7-bit address and
// serves a byte-wide register file through an auto-incrementing pointer.
module uvmt_i2c_st_tagt_dut #(
   parameter logic [6:0] TAGT_ADDR = 7'h50,
   parameter int         NUM_REGS  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        scl_i,
   input  logic                        sda_i,
   output logic                        sda_oe,
   output logic                        busy,
   output logic                        reg_wr_en,
   output logic [$clog2(NUM_REGS)-1:0] reg_wr_addr,
   output logic [7:0]                  reg_wr_data
);

   import uvmt_i2c_st_tagt_pkg::*;

   localparam int PTR_W = $clog2(NUM_REGS);

   logic scl_lvl;
   logic scl_rise;
   logic scl_fall;
   logic sda_lvl;
   logic sda_rise;
   logic sda_fall;

   uvmt_i2c_st_tagt_sync u_scl_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (scl_i),
      .level    (scl_lvl),
      .rise     (scl_rise),
      .fall     (scl_fall)
   );

   uvmt_i2c_st_tagt_sync u_sda_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (sda_i),
      .level    (sda_lvl),
      .rise     (sda_rise),
      .fall     (sda_fall)
   );

   logic scl_edge;
   logic start_det;
   logic stop_det;

   // An SCL edge in the same cycle wins: the SDA change is treated as data.
   assign scl_edge  = scl_rise | scl_fall;
   assign start_det = sda_fall & scl_lvl & ~scl_edge;
   assign stop_det  = sda_rise & scl_lvl & ~scl_edge;

   tagt_state_e          state;
   tagt_state_e          state_d;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [BIT_CNT_W-1:0] bit_cnt_d;
   logic [7:0]           shift;
   logic [7:0]           shift_d;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     ptr_d;
   logic [PTR_W-1:0]     ptr_inc;
   logic                 rw;
   logic                 rw_d;
   logic                 sda_oe_d;
   logic                 wr_en_d;
   logic [PTR_W-1:0]     wr_addr_d;
   logic [7:0]           wr_data_d;
   logic [7:0]           byte_in;
   logic [7:0]           regs [NUM_REGS];

   assign byte_in = {shift[6:0], sda_lvl};
   assign ptr_inc = ptr + PTR_W'(1);

   assign busy = (state == ST_ADDR_ACK) || (state == ST_WR_PTR)  ||
                 (state == ST_WR_DATA)  || (state == ST_WR_ACK)  ||
                 (state == ST_RD_DATA)  || (state == ST_RD_ACK);

   // Next-state and datapath decode. START/STOP override whatever the FSM
   // was doing; otherwise each state reacts only to synced SCL edges.
   // In the ACK states the current sda_oe tells the first fall (start
   // pulling) from the second fall (release and move on).
   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      shift_d   = shift;
      ptr_d     = ptr;
      rw_d      = rw;
      sda_oe_d  = sda_oe;
      wr_en_d   = 1'b0;
      wr_addr_d = reg_wr_addr;
      wr_data_d = reg_wr_data;

      if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end

            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                  if (bit_cnt == BIT_CNT_W'(7)) begin
                     bit_cnt_d = '0;
                     if (byte_in[7:1] == TAGT_ADDR) begin
                        state_d = ST_ADDR_ACK;
                        rw_d    = byte_in[0];
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end

            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe_d = oe_for_bit(ACK_BIT);
                  end else begin
                     bit_cnt_d = '0;
                     if (rw) begin
                        state_d  = ST_RD_DATA;
                        shift_d  = regs[ptr];
                        sda_oe_d = oe_for_bit(regs[ptr][7]);
                     end else begin
                        state_d  = ST_WR_PTR;
                        sda_oe_d = 1'b0;
                     end
                  end
               end
            end

            ST_WR_PTR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                  if (bit_cnt == BIT_CNT_W'(7)) begin
                     bit_cnt_d = '0;
                     state_d   = ST_WR_ACK;
                     if (state == ST_WR_PTR) begin
                        ptr_d = byte_in[PTR_W-1:0];
                     end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr;
                        wr_data_d = byte_in;
                        ptr_d     = ptr_inc;
                     end
                  end
               end
            end

            ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe_d = oe_for_bit(ACK_BIT);
                  end else begin
                     sda_oe_d  = 1'b0;
                     state_d   = ST_WR_DATA;
                     bit_cnt_d = '0;
                  end
               end
            end

            ST_RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
               end else if (scl_fall) begin
                  if (bit_cnt == '0) begin
                     sda_oe_d = oe_for_bit(shift[7]);
                  end else if (bit_cnt == BIT_CNT_W'(8)) begin
                     sda_oe_d  = 1'b0;
                     state_d   = ST_RD_ACK;
                     bit_cnt_d = '0;
                  end else begin
                     shift_d  = {shift[6:0], 1'b0};
                     sda_oe_d = oe_for_bit(shift[6]);
                  end
               end
            end

            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl == NACK_BIT) begin
                     state_d = ST_IGNORE;
                  end else begin
                     ptr_d     = ptr_inc;
                     shift_d   = regs[ptr_inc];
                     state_d   = ST_RD_DATA;
                     bit_cnt_d = '0;
                  end
               end
            end

            ST_IGNORE: begin
               state_d = ST_IGNORE;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; reset drops SDA and discards any byte
   // in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         ptr         <= '0;
         rw          <= 1'b0;
         sda_oe      <= 1'b0;
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
      end else begin
         state       <= state_d;
         bit_cnt     <= bit_cnt_d;
         shift       <= shift_d;
         ptr         <= ptr_d;
         rw          <= rw_d;
         sda_oe      <= sda_oe_d;
         reg_wr_en   <= wr_en_d;
         reg_wr_addr <= wr_addr_d;
         reg_wr_data <= wr_data_d;
      end
   end

   // Register file updates on the same edge the write strobe is launched.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en_d) begin
         regs[wr_addr_d] <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_uvmt_i2c_st_tagt_dut.sv
// Self-checking bench: acts as the I2C controller, keeps a register model,
// and scoreboards write strobes and read data against it.
module tb_uvmt_i2c_st_tagt_dut;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl;
   logic       sda_drv;
   logic       sda_bus;
   logic       sda_oe;
   logic       busy;
   logic       reg_wr_en;
   logic [3:0] reg_wr_addr;
   logic [7:0] reg_wr_data;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_item_t;

   wr_item_t   wr_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] model_regs [16];
   logic [3:0] model_ptr;
   logic       busy_seen;

   // Open-drain bus: either side can pull SDA low.
   assign sda_bus = sda_drv & ~sda_oe;

   // 100 MHz system clock.
   always #5 clk = ~clk;

   uvmt_i2c_st_tagt_dut #(
      .TAGT_ADDR (7'h50),
      .NUM_REGS  (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .scl_i       (scl),
      .sda_i       (sda_bus),
      .sda_oe      (sda_oe),
      .busy        (busy),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (!reset && reg_wr_en) begin
         if (wr_q.size() == 0) begin
            checkOutput("wr_unexpected", {31'd0, reg_wr_en}, 32'd0);
         end else begin
            wr_item_t e;
            e = wr_q.pop_front();
            checkOutput("wr_addr", {28'd0, reg_wr_addr}, {28'd0, e.addr});
            checkOutput("wr_data", {24'd0, reg_wr_data}, {24'd0, e.data});
         end
      end
   end

   // Remembers whether busy was ever seen high since it was last cleared.
   always @(negedge clk) begin
      if (busy) busy_seen = 1'b1;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL period starting and ending with SCL low; returns the SDA level
   // seen in the middle of the high phase.
   task automatic bus_bit(input logic b, output logic sampled);
      wait_clks(4);
      sda_drv = b;
      wait_clks(4);
      scl = 1'b1;
      wait_clks(4);
      sampled = sda_bus;
      wait_clks(4);
      scl = 1'b0;
   endtask

   task automatic send_start();
      wait_clks(4);
      sda_drv = 1'b1;
      wait_clks(4);
      scl = 1'b1;
      wait_clks(6);
      sda_drv = 1'b0;
      wait_clks(6);
      scl = 1'b0;
   endtask

   task automatic send_stop();
      wait_clks(4);
      sda_drv = 1'b0;
      wait_clks(4);
      scl = 1'b1;
      wait_clks(6);
      sda_drv = 1'b1;
      wait_clks(8);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i]);
      bus_bit(ack_bit, s);
   endtask

   // Write transaction: address/W, pointer byte, then up to two data bytes.
   task automatic applyStimulus(input logic [7:0] ptr_byte, input int n_data,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input bit do_stop);
      logic       ack;
      logic [7:0] data [2];
      wr_item_t   e;
      data[0] = d0;
      data[1] = d1;
      send_start();
      send_byte({7'h50, 1'b0}, ack);
      checkOutput("addr_w_ack", {31'd0, ack}, 32'd0);
      checkOutput("busy_addressed", {31'd0, busy}, 32'd1);
      send_byte(ptr_byte, ack);
      checkOutput("ptr_ack", {31'd0, ack}, 32'd0);
      model_ptr = ptr_byte[3:0];
      for (int k = 0; k < n_data; k++) begin
         e.addr = model_ptr;
         e.data = data[k];
         wr_q.push_back(e);
         model_regs[model_ptr] = data[k];
         model_ptr++;
         send_byte(data[k], ack);
         checkOutput("data_ack", {31'd0, ack}, 32'd0);
      end
      if (do_stop) begin
         send_stop();
         checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
         checkOutput("wr_pending", wr_q.size(), 32'd0);
      end
   endtask

   // Read transaction: address/R, n bytes, ACK on all but the last.
   task automatic applyRead(input int n);
      logic       ack;
      logic       ack_bit;
      logic [7:0] d;
      logic [7:0] exp_d;
      send_start();
      send_byte({7'h50, 1'b1}, ack);
      checkOutput("addr_r_ack", {31'd0, ack}, 32'd0);
      checkOutput("busy_read", {31'd0, busy}, 32'd1);
      for (int k = 0; k < n; k++) begin
         rd_q.push_back(model_regs[model_ptr]);
         ack_bit = (k == n - 1);
         read_byte(ack_bit, d);
         exp_d = rd_q.pop_front();
         checkOutput("rd_data", {24'd0, d}, {24'd0, exp_d});
         if (!ack_bit) model_ptr++;
      end
      wait_clks(6);
      checkOutput("sda_released_nack", {31'd0, sda_oe}, 32'd0);
      checkOutput("busy_after_nack", {31'd0, busy}, 32'd0);
      send_stop();
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_sda_oe"}, {31'd0, sda_oe}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_wr_en"}, {31'd0, reg_wr_en}, 32'd0);
      checkOutput({tag, "_wr_addr"}, {28'd0, reg_wr_addr}, 32'd0);
      checkOutput({tag, "_wr_data"}, {24'd0, reg_wr_data}, 32'd0);
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [3:0] part;

      reset     = 1'b1;
      scl       = 1'b1;
      sda_drv   = 1'b1;
      busy_seen = 1'b0;
      model_ptr = '0;
      for (int i = 0; i < 16; i++) model_regs[i] = '0;
      wait_clks(5);
      check_reset_values("reset");
      reset = 1'b0;
      wait_clks(10);

      $display("[TB] write 0xA5, 0x5A from pointer 3");
      applyStimulus(8'h03, 2, 8'hA5, 8'h5A, 1'b1);

      $display("[TB] pointer 3, repeated start, read two bytes");
      applyStimulus(8'h03, 0, 8'h00, 8'h00, 1'b0);
      applyRead(2);

      $display("[TB] foreign address 0x51");
      wait_clks(10);
      busy_seen = 1'b0;
      send_start();
      send_byte({7'h51, 1'b0}, ack);
      checkOutput("bad_addr_nack", {31'd0, ack}, 32'd1);
      send_byte(8'h07, ack);
      checkOutput("ignored_byte_nack", {31'd0, ack}, 32'd1);
      send_stop();
      checkOutput("bad_addr_busy", {31'd0, busy_seen}, 32'd0);
      applyStimulus(8'h03, 0, 8'h00, 8'h00, 1'b0);
      applyRead(1);

      $display("[TB] pointer wrap 15 -> 0");
      applyStimulus(8'h0F, 2, 8'h11, 8'h22, 1'b1);

      $display("[TB] reset in the middle of a read");
      applyStimulus(8'h00, 0, 8'h00, 8'h00, 1'b0);
      send_start();
      send_byte({7'h50, 1'b1}, ack);
      checkOutput("rst_addr_ack", {31'd0, ack}, 32'd0);
      for (int i = 3; i >= 0; i--) bus_bit(1'b1, part[i]);
      checkOutput("rst_partial_bits", {28'd0, part}, 32'h2);
      wait_clks(6);
      checkOutput("rst_bit5_driven", {31'd0, sda_oe}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_sda_release", {31'd0, sda_oe}, 32'd0);
      scl     = 1'b1;
      sda_drv = 1'b1;
      wait_clks(4);
      check_reset_values("midreset");
      reset = 1'b0;
      model_ptr = '0;
      for (int i = 0; i < 16; i++) model_regs[i] = '0;
      wait_clks(10);
      applyRead(1);

      $display("[TB] pointer byte 0xF2 truncates to 2");
      applyStimulus(8'hF2, 1, 8'h77, 8'h00, 1'b1);
      applyStimulus(8'h02, 0, 8'h00, 8'h00, 1'b0);
      applyRead(2);

      wait_clks(10);
      checkOutput("wr_queue_drained", wr_q.size(), 32'd0);
      bus_bit(1'b1, s);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
